// File: rtl/addsub_flag_unit_if.sv
// addsub_flag_unit_if: start/busy/done handshake, operands, result and N/V/C/Z flags
interface addsub_flag_unit_if #(parameter int WIDTH = 32);
  logic start;
  logic sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  logic FlagN;
  logic FlagV;
  logic FlagC;
  logic FlagZ;
  modport master (output start, sub, A, B, input busy, done, result, FlagN, FlagV, FlagC, FlagZ);
  modport slave (input start, sub, A, B, output busy, done, result, FlagN, FlagV, FlagC, FlagZ);
endinterface

// File: rtl/addsub_flag_unit.sv
// addsub_flag_unit: chunked adder/subtractor with N/V/C/Z flags and a registered carry between slices.
// Define ADDSUB_SINGLE_CYCLE_EN to compute the full-width result at the accepted start edge instead.
module addsub_flag_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic clk,
  input logic reset_n,
  addsub_flag_unit_if.slave io
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic accept, commit, c_msb, c_out;
  logic [WIDTH-1:0] res_n, result;
  logic fn, fv, fc, fz;
  assign accept = io.start && state != RUN;
`ifdef ADDSUB_SINGLE_CYCLE_EN
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0] full;
  assign commit = accept;
  always_comb begin
    bx = io.B ^ {WIDTH{io.sub}};
    full = {1'b0, io.A} + {1'b0, bx} + (WIDTH+1)'(io.sub);
    res_n = full[WIDTH-1:0];
    c_out = full[WIDTH];
    c_msb = io.A[WIDTH-1] ^ bx[WIDTH-1] ^ full[WIDTH-1];
    state_n = accept ? DONE : IDLE;
  end
`else
  logic [WIDTH-1:0] a_r, b_r, acc;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0] sum;
  logic [IW-1:0] idx;
  logic carry, last;
  assign last = idx == IW'(NCH - 1);
  assign commit = state == RUN && last;
  always_comb begin
    a_sl = a_r[int'(idx)*CHUNK +: CHUNK];
    b_sl = b_r[int'(idx)*CHUNK +: CHUNK];
    sum = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK+1)'(carry);
    res_n = acc;
    res_n[int'(idx)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    c_out = sum[CHUNK];
    c_msb = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sum[CHUNK-1];
    state_n = state == RUN ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      carry <= 1'b0;
      idx <= '0;
    end else if (accept) begin
      a_r <= io.A;
      b_r <= io.B ^ {WIDTH{io.sub}};
      acc <= '0;
      carry <= io.sub;
      idx <= '0;
    end else if (state == RUN) begin
      acc <= res_n;
      carry <= c_out;
      idx <= idx + 1'b1;
    end
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // Architectural outputs only change when an operation completes.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      result <= '0;
      {fn, fv, fc, fz} <= '0;
    end else if (commit) begin
      result <= res_n;
      fn <= res_n[WIDTH-1];
      fv <= c_msb ^ c_out;
      fc <= c_out;
      fz <= ~|res_n;
    end
  assign io.busy = state == RUN;
  assign io.done = state == DONE;
  assign io.result = result;
  assign io.FlagN = fn;
  assign io.FlagV = fv;
  assign io.FlagC = fc;
  assign io.FlagZ = fz;
endmodule
